// File: rtl/cmp_share_pkg.sv
// cmp_share_pkg: shared types and constants for the shared-comparator arbiter.
//   state_e       response register occupancy (ST_EMPTY / ST_FULL)
//   cmp_result_t  three-way compare result, exactly one bit set when valid
//   CMP_N_DEFAULT default operand width
//   CMP_R_DEFAULT default requester count
//   iw_of()       index width for R requesters, never less than 1
package cmp_share_pkg;

    localparam int unsigned CMP_N_DEFAULT = 8;
    localparam int unsigned CMP_R_DEFAULT = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic greater;
        logic equal;
        logic lesser;
    } cmp_result_t;

    function automatic int unsigned iw_of(int unsigned r);
        return (r > 2) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/cmp_share_arb_if.sv
// cmp_share_arb_if: request/response bundle between client engines and the arbiter.
// Parameters: N operand width, R requester count.
//   req_valid/req_ready  per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b          packed operands, requester i at [i*N +: N]
//   rsp_valid/rsp_ready  single response handshake
//   rsp_id               winning requester index
//   rsp_greater/equal/lesser  registered three-way result
// Modports: master = client side, slave = arbiter side.
interface cmp_share_arb_if
    import cmp_share_pkg::*;
#(
    parameter int unsigned N = CMP_N_DEFAULT,
    parameter int unsigned R = CMP_R_DEFAULT
) ();
    localparam int unsigned IW = iw_of(R);

    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic           rsp_greater;
    logic           rsp_equal;
    logic           rsp_lesser;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_greater, rsp_equal, rsp_lesser
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_greater, rsp_equal, rsp_lesser
    );

endinterface

// File: rtl/rr_grant.sv
// rr_grant: rotating-priority grant. Priority starts at ptr and walks upward,
// wrapping from R-1 to 0; the first asserted request wins.
// Ports:
//   req        R-wide request vector
//   ptr        highest-priority index (expected < R)
//   gnt        one-hot grant, zero when no request
//   gnt_idx    encoded index of the grant
//   gnt_valid  any request granted
module rr_grant #(
    parameter int unsigned R  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [R-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [R-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int unsigned off = 0; off < R; off++) begin
            idx = IW'((32'(ptr) + off) % R);
            if (!gnt_valid && req[idx]) begin
                gnt[idx]  = 1'b1;
                gnt_idx   = idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_share_arb.sv
// cmp_share_arb: round-robin sharing of one N-bit magnitude comparator among
// R requesters, with a single-entry registered response.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    cmp_share_arb_if.slave (request vector in, response out)
// Build option: define CMP_SHARE_SIGNED_EN for two's-complement comparison;
// the default build compares unsigned.
module cmp_share_arb
    import cmp_share_pkg::*;
#(
    parameter int unsigned N = CMP_N_DEFAULT,
    parameter int unsigned R = CMP_R_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    cmp_share_arb_if.slave   bus
);

    localparam int unsigned IW = iw_of(R);

    state_e        state_q;
    cmp_result_t   rsp_q;
    logic [IW-1:0] rsp_id_q;
    logic [IW-1:0] ptr_q;

    logic [R-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          can_accept;
    logic          transfer;
    logic [N-1:0]  sel_a;
    logic [N-1:0]  sel_b;
    cmp_result_t   cmp_res;

    rr_grant #(
        .R  (R),
        .IW (IW)
    ) u_rr_grant (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // rst_n gates acceptance so no req_ready escapes while reset is held.
    assign can_accept    = rst_n && ((state_q == ST_EMPTY) || bus.rsp_ready);
    assign bus.req_ready = can_accept ? gnt : '0;
    assign transfer      = can_accept && gnt_valid;

    always_comb begin
        sel_a = bus.req_a[gnt_idx*N +: N];
        sel_b = bus.req_b[gnt_idx*N +: N];
`ifdef CMP_SHARE_SIGNED_EN
        cmp_res.greater = $signed(sel_a) > $signed(sel_b);
        cmp_res.lesser  = $signed(sel_a) < $signed(sel_b);
`else
        cmp_res.greater = sel_a > sel_b;
        cmp_res.lesser  = sel_a < sel_b;
`endif
        cmp_res.equal   = sel_a == sel_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            rsp_q    <= '0;
            rsp_id_q <= '0;
            ptr_q    <= '0;
        end else begin
            // A transfer always wins over a drain, so back-to-back compares
            // keep rsp_valid high.
            if (transfer) begin
                state_q  <= ST_FULL;
                rsp_q    <= cmp_res;
                rsp_id_q <= gnt_idx;
                ptr_q    <= (gnt_idx == IW'(R - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                case (state_q)
                    ST_FULL: begin
                        if (bus.rsp_ready) begin
                            state_q <= ST_EMPTY;
                        end
                    end
                    default: state_q <= ST_EMPTY;
                endcase
            end
        end
    end

    assign bus.rsp_valid   = (state_q == ST_FULL);
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_greater = rsp_q.greater;
    assign bus.rsp_equal   = rsp_q.equal;
    assign bus.rsp_lesser  = rsp_q.lesser;

endmodule

// File: tb/tb_cmp_share_arb.sv
// tb_cmp_share_arb: directed stimulus with a response scoreboard. The stimulus
// process pushes hand-computed responses; a negedge monitor pops on every
// response handshake and compares.
module tb_cmp_share_arb;

    localparam int unsigned N  = 8;
    localparam int unsigned R  = 4;
    localparam int unsigned IW = 2;

    // Expected result encoding {greater, equal, lesser}.
    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    typedef struct {
        logic [IW-1:0] id;
        logic [2:0]    res;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t exp_q[$];
    int   n_vec;
    int   n_miss;

    cmp_share_arb_if #(.N(N), .R(R)) bus ();

    cmp_share_arb #(.N(N), .R(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[i*N +: N] = a;
        bus.req_b[i*N +: N] = b;
    endtask

    task automatic push(input logic [IW-1:0] id, input logic [2:0] res);
        exp_t e;
        e.id  = id;
        e.res = res;
        exp_q.push_back(e);
    endtask

    // Monitor: response handshake completes at the following posedge.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL rsp_unexpected: got id %0d, expected no response", bus.rsp_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                chk("rsp_flags", 32'({bus.rsp_greater, bus.rsp_equal, bus.rsp_lesser}),
                    32'(e.res));
            end
        end
    end

    initial begin
        logic [IW-1:0] rr_ids [8];
        logic [2:0]    rr_res [4];
        logic [R-1:0]  oh;
        logic [IW-1:0] wr_ids [3];
        logic [2:0]    sign_res;
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        set_op(0, 8'h01, 8'h02);

        // Reset holds everything quiet even with all requests valid.
        repeat (3) tick();
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("reset_rsp_id", 32'(bus.rsp_id), 0);
        chk("reset_rsp_flags", 32'({bus.rsp_greater, bus.rsp_equal, bus.rsp_lesser}), 0);
        chk("reset_req_ready", 32'(bus.req_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("first_grant", 32'(bus.req_ready), 32'(4'b0001));
        push(2'd0, LT);
        tick();
        bus.req_valid = '0;
        tick();

        // Single request from requester 2 (ptr is now 1).
        set_op(2, 8'h10, 8'h20);
        bus.req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(bus.req_ready), 32'(4'b0100));
        push(2'd2, LT);
        tick();
        bus.req_valid = '0;
        #1;
        chk("single_ready_drop", 32'(bus.req_ready), 0);
        tick();

        // Round-robin, all valid, ptr = 3.
        set_op(0, 8'h55, 8'h55);
        set_op(1, 8'h30, 8'h20);
        set_op(2, 8'h55, 8'h55);
        set_op(3, 8'h00, 8'h7F);
        rr_res = '{EQ, GT, EQ, LT};
        rr_ids = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            oh = '0;
            oh[rr_ids[k]] = 1'b1;
            chk("rr_grant", 32'(bus.req_ready), 32'(oh));
            push(rr_ids[k], rr_res[rr_ids[k]]);
            tick();
        end
        bus.req_valid = '0;
        tick();

        // Backpressure: requester 1 wins (ptr 3), response held 5 cycles.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        #1;
        chk("bp_first_grant", 32'(bus.req_ready), 32'(4'b0010));
        push(2'd1, GT);
        tick();
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready_zero", 32'(bus.req_ready), 0);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
            chk("bp_rsp_id", 32'(bus.rsp_id), 1);
            chk("bp_rsp_greater", 32'(bus.rsp_greater), 1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(bus.req_ready), 32'(4'b0001));
        push(2'd0, EQ);
        tick();
        bus.req_valid = '0;
        tick();

        // Move ptr to 3 via requester 2, then alternate 3 / 0 / 3.
        set_op(2, 8'h20, 8'h10);
        bus.req_valid = 4'b0100;
        #1;
        chk("wrap_setup", 32'(bus.req_ready), 32'(4'b0100));
        push(2'd2, GT);
        tick();
        bus.req_valid = 4'b1001;
        wr_ids = '{2'd3, 2'd0, 2'd3};
        for (int k = 0; k < 3; k++) begin
            #1;
            oh = '0;
            oh[wr_ids[k]] = 1'b1;
            chk("wrap_grant", 32'(bus.req_ready), 32'(oh));
            push(wr_ids[k], (wr_ids[k] == 2'd3) ? LT : EQ);
            tick();
        end
        bus.req_valid = '0;
        tick();

        // Sign handling, ptr = 0, requester 1.
`ifdef CMP_SHARE_SIGNED_EN
        sign_res = LT;
`else
        sign_res = GT;
`endif
        set_op(1, 8'h80, 8'h01);
        bus.req_valid = 4'b0010;
        #1;
        chk("sign_grant", 32'(bus.req_ready), 32'(4'b0010));
        push(2'd1, sign_res);
        tick();
        bus.req_valid = '0;
        tick();

        // Reset while FULL drops the response without a clock edge.
        bus.rsp_ready = 1'b0;
        set_op(2, 8'h80, 8'h80);
        bus.req_valid = 4'b0100;
        #1;
        chk("rst_mid_grant", 32'(bus.req_ready), 32'(4'b0100));
        tick();
        bus.req_valid = 4'b1100;
        chk("rst_mid_full", 32'(bus.rsp_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_mid_rsp_id", 32'(bus.rsp_id), 0);
        chk("rst_mid_flags", 32'({bus.rsp_greater, bus.rsp_equal, bus.rsp_lesser}), 0);
        chk("rst_mid_ready", 32'(bus.req_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        chk("post_rst_grant", 32'(bus.req_ready), 32'(4'b0100));
        push(2'd2, EQ);
        tick();
        bus.req_valid = '0;
        tick();
        tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cmp_share_arb.md
# cmp_share_arb

Round-robin scheduler that shares one N-bit magnitude comparator between R requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the three-way compare result with the winner's ID, and holds it on a single response port until it is consumed. It sits between the client engines and the comparison datapath, so several clients can use one comparator.

## Interface
- N, 8, operand width in bits (≥1)
- R, 4, number of requesters (≥2); IW = max(1, $clog2(R))
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- req_valid  input  R  per-requester request valid
- req_ready  output  R  per-requester accept; one-hot or zero
- req_a  input  R*N  operand A; requester i occupies bits [i*N +: N]
- req_b  input  R*N  operand B; same packing as req_a
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  IW  index of the requester that produced the response
- rsp_greater  output  1  A > B
- rsp_equal  output  1  A == B
- rsp_lesser  output  1  A < B

## Operation
- Single-entry output register. States: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = !rsp_valid || rsp_ready.
- Grant selection:
  - Round-robin pointer ptr (IW bits) is the highest-priority index.
  - Search runs ptr, ptr+1, …, R-1, 0, …, ptr-1 and grants the first asserted req_valid.
- req_ready[g] = can_accept && req_valid[g] for the granted g. All other bits are 0.
- A transfer occurs when req_valid[g] && req_ready[g]. On a transfer:
  - The register loads greater/equal/lesser from req_a[g] vs req_b[g], plus rsp_id = g.
  - ptr becomes (g+1) mod R; when g = R-1, ptr wraps to 0.
  - The state becomes FULL.
- With no transfer and rsp_valid && rsp_ready, the state becomes EMPTY.
- Transfer and response handshake in the same cycle: the register reloads and rsp_valid stays 1. This gives 1 compare/cycle throughput.
- While FULL and !rsp_ready, the response fields are frozen, all req_ready are 0, and ptr is unchanged.
- Exactly one of greater/equal/lesser is 1 whenever rsp_valid=1.
- Default comparison is unsigned over N bits.
- Requesters hold req_valid, req_a and req_b stable until accepted. The arbiter does not buffer unaccepted requests.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_greater=0, rsp_equal=0, rsp_lesser=0, ptr=0. req_ready=0 while rst_n=0.
- Latency: request accepted at edge k → response visible after edge k (cycle k+1).
- req_ready is combinational from req_valid, rsp_valid and rsp_ready. All rsp_* outputs are registers.
- No requester starves: a continuously valid requester is granted within R accepted transfers.
- Reset asserted mid-operation: a held response is dropped immediately and ptr returns to 0. The first grant after reset goes to the lowest asserted index.

## Configuration
- CMP_SHARE_SIGNED_EN defined: operands are compared as two's-complement signed. For N=8, 8'h80 < 8'h01.
- CMP_SHARE_SIGNED_EN undefined: unsigned comparison. For N=8, 8'h80 > 8'h01.
- Handshake and arbitration are identical in both builds.

## Structure
- Shared package cmp_share_pkg holds:
  - state encoding (ST_EMPTY, ST_FULL)
  - result struct/encoding (greater, equal, lesser)
  - default N and R constants
- One sub-module, rr_grant: R-wide rotating-priority grant from a request vector and ptr. Outputs a one-hot grant and its encoded index.
- The comparison is inline in the top level and guarded by the macro.

## Test plan
- Reset: hold rst_n=0 with all req_valid=1 → rsp_valid=0, all rsp_* = 0, req_ready=0. Release → first grant is index 0.
- Single request: req 2, A=8'h10, B=8'h20, rsp_ready=1 → req_ready=4'b0100 for one cycle. Next cycle rsp_valid=1, rsp_id=2, rsp_lesser=1.
- Round-robin: all four requesters valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,… at 1 per cycle. Equal operands (8'h55/8'h55) give rsp_equal=1.
- Backpressure: rsp_ready=0 for 5 cycles while FULL → response fields stable, req_ready=0. Raise rsp_ready → the next grant is accepted in that same cycle.
- Wrap and fairness: only req 3 and req 0 valid, ptr=3 → grant 3, then 0, then 3. ptr wraps to 0 after grant 3.
- Sign handling: A=8'h80, B=8'h01 → rsp_greater=1 when unsigned; rsp_lesser=1 with CMP_SHARE_SIGNED_EN. Also assert rst_n low while FULL → rsp_valid drops to 0 without waiting for a clock edge.
